hall_input_conditioner: RTL and testbench

Front-end stage directly upstream of angle_tracking_unit. Takes the two raw, asynchronous Hall sensor lines from the motor.
- Synchronises and glitch-filters both lines, then drives clean hall_1/hall_2 to the ATU.
- Decodes quadrature steps and produces the ATU's clockwise input.
- Measures hall_2 period for speed estimation and flags stall and illegal transitions.

---
 rtl/hall_input_conditioner.sv | 171 +++++++++++++++++
 tb/tb_hall_input_conditioner.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_input_conditioner.sv
// Hall sensor front end: synchronises and glitch-filters two raw Hall lines, decodes
// quadrature direction and illegal jumps, and measures the hall_2 period with stall detection.
module hall_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int PERIOD_W    = 16,
    parameter int STALL_LIMIT = 50000
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                hall_1_raw,
    input  logic                hall_2_raw,
    output logic                hall_1,
    output logic                hall_2,
    output logic                clockwise,
    output logic                step_pulse,
    output logic                dir_error,
    output logic [7:0]          err_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]    CNT_TOP  = CNT_W'(FILTER_LEN - 1);
    localparam logic [PERIOD_W-1:0] LIMIT    = PERIOD_W'(STALL_LIMIT);
    localparam logic [PERIOD_W-1:0] LIMIT_M1 = PERIOD_W'(STALL_LIMIT - 1);

    // Bit 0 carries hall_1, bit 1 carries hall_2 through both channels.
    logic [1:0] raw;
    logic [1:0] filt;

    assign raw = {hall_2_raw, hall_1_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   filt_reg;
            logic                   synced;

            assign synced = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw[gi]};
                end
            end

            // Output flips only after FILTER_LEN consecutive disagreeing samples.
            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (synced == filt_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_TOP) begin
                    filt_reg <= synced;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    assign hall_1 = filt[0];
    assign hall_2 = filt[1];

    logic h1p_reg;
    logic h2p_reg;
    logic chg_1;
    logic chg_2;
    logic one_change;
    logic two_change;
    logic cw_decoded;

    assign chg_1      = hall_1 ^ h1p_reg;
    assign chg_2      = hall_2 ^ h2p_reg;
    assign one_change = chg_1 ^ chg_2;
    assign two_change = chg_1 & chg_2;
    // For a single-bit change, clockwise iff old hall_1 equals new hall_2.
    assign cw_decoded = ~(h1p_reg ^ hall_2);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            h1p_reg    <= 1'b0;
            h2p_reg    <= 1'b0;
            clockwise  <= 1'b1;
            step_pulse <= 1'b0;
            dir_error  <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            h1p_reg    <= hall_1;
            h2p_reg    <= hall_2;
            step_pulse <= one_change;
            dir_error  <= two_change;
            if (one_change) begin
                clockwise <= cw_decoded;
            end
            if (two_change && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Period tracker: IDLE has no reference edge, RUN has one, STALL timed out.
    typedef enum logic [1:0] {
        MEAS_IDLE,
        MEAS_RUN,
        MEAS_STALL
    } meas_state_t;

    meas_state_t         state_reg;
    meas_state_t         state_next;
    logic [PERIOD_W-1:0] per_cnt_reg;
    logic [PERIOD_W-1:0] per_cnt_next;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] period_next;
    logic                valid_reg;
    logic                valid_next;
    logic                rise;

    assign rise = hall_2 & ~h2p_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg   <= MEAS_IDLE;
            per_cnt_reg <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            per_cnt_reg <= per_cnt_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        per_cnt_next = per_cnt_reg;
        period_next  = period_reg;
        valid_next   = valid_reg;
        if (rise) begin
            // An edge beats a simultaneous timeout; only a referenced edge measures.
            per_cnt_next = '0;
            state_next   = MEAS_RUN;
            if (state_reg == MEAS_RUN) begin
                period_next = per_cnt_reg + PERIOD_W'(1);
                valid_next  = 1'b1;
            end
        end else if (per_cnt_reg != LIMIT) begin
            per_cnt_next = per_cnt_reg + PERIOD_W'(1);
            if (per_cnt_reg == LIMIT_M1) begin
                state_next = MEAS_STALL;
                valid_next = 1'b0;
            end
        end
    end

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign stalled      = (state_reg == MEAS_STALL);

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Randomised bench for hall_input_conditioner: a sample-history reference model feeds an
// event scoreboard and a per-cycle output comparison.
module tb_hall_input_conditioner;

    localparam int SYNC = 2;
    localparam int FL   = 4;
    localparam int PW   = 16;
    localparam int LIM  = 100;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          hall_1_raw = 1'b0;
    logic          hall_2_raw = 1'b0;
    logic          hall_1;
    logic          hall_2;
    logic          clockwise;
    logic          step_pulse;
    logic          dir_error;
    logic [7:0]    err_count;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stalled;

    hall_input_conditioner #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FL),
        .PERIOD_W   (PW),
        .STALL_LIMIT(LIM)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .hall_1_raw  (hall_1_raw),
        .hall_2_raw  (hall_2_raw),
        .hall_1      (hall_1),
        .hall_2      (hall_2),
        .clockwise   (clockwise),
        .step_pulse  (step_pulse),
        .dir_error   (dir_error),
        .err_count   (err_count),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cyc;
        bit is_err;
        bit cw;
    } ev_t;

    ev_t evq[$];
    bit  h1_hist[SYNC+FL];
    bit  h2_hist[SYNC+FL];
    bit  mf1 = 1'b0, mf2 = 1'b0, mp1 = 1'b0, mp2 = 1'b0;
    bit  m_cw = 1'b1, m_valid = 1'b0, m_stalled = 1'b0, m_have_ref = 1'b0;
    int  m_errs = 0, m_period = 0, m_cyc = 0, m_last = 0;
    bit  model_ready = 1'b0;

    // Electrical position along the clockwise sequence 00,10,11,01.
    function automatic int pos_of(input bit a, input bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC + FL; i++) begin
            h1_hist[i] = 1'b0;
            h2_hist[i] = 1'b0;
        end
        mf1 = 0; mf2 = 0; mp1 = 0; mp2 = 0;
        m_cw = 1; m_valid = 0; m_stalled = 0; m_have_ref = 0;
        m_errs = 0; m_period = 0; m_last = m_cyc;
        evq.delete();
        model_ready = 1'b1;
    endtask

    task automatic model_step();
        bit all1, all2, n1, n2, d1, d2, st, de;
        m_cyc++;
        for (int i = SYNC + FL - 1; i > 0; i--) begin
            h1_hist[i] = h1_hist[i-1];
            h2_hist[i] = h2_hist[i-1];
        end
        h1_hist[0] = hall_1_raw;
        h2_hist[0] = hall_2_raw;
        all1 = 1; all2 = 1;
        for (int j = 0; j < FL; j++) begin
            if (h1_hist[SYNC+j] == mf1) all1 = 0;
            if (h2_hist[SYNC+j] == mf2) all2 = 0;
        end
        n1 = all1 ? !mf1 : mf1;
        n2 = all2 ? !mf2 : mf2;
        d1 = mf1 ^ mp1;
        d2 = mf2 ^ mp2;
        st = d1 ^ d2;
        de = d1 & d2;
        if (st) m_cw = (((pos_of(mf1, mf2) - pos_of(mp1, mp2)) & 3) == 1);
        if (de && m_errs < 255) m_errs++;
        if (st || de) evq.push_back('{m_cyc, de, m_cw});
        if (mf2 && !mp2) begin
            if (m_have_ref) begin
                m_period = m_cyc - m_last;
                m_valid  = 1;
            end
            m_have_ref = 1;
            m_stalled  = 0;
            m_last     = m_cyc;
        end else if (m_cyc - m_last == LIM) begin
            m_stalled  = 1;
            m_valid    = 0;
            m_have_ref = 0;
        end
        mp1 = mf1; mp2 = mf2;
        mf1 = n1;  mf2 = n2;
    endtask

    initial begin
        forever begin
            @(posedge CLK or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int dut_steps = 0;
    int dut_derr  = 0;
    int h1_high   = 0;

    initial begin
        ev_t ev;
        forever begin
            @(negedge CLK);
            if (model_ready) begin
                check("hall_1", 32'(hall_1), 32'(mf1));
                check("hall_2", 32'(hall_2), 32'(mf2));
                check("clockwise", 32'(clockwise), 32'(m_cw));
                check("err_count", 32'(err_count), m_errs);
                check("period", 32'(period), m_period);
                check("period_valid", 32'(period_valid), 32'(m_valid));
                check("stalled", 32'(stalled), 32'(m_stalled));
                if (step_pulse && dir_error) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pulse_exclusive: got step_pulse=1 dir_error=1, expected at most one");
                end
                if (step_pulse) dut_steps++;
                if (dir_error) dut_derr++;
                if (hall_1) h1_high++;
                if (step_pulse || dir_error) begin
                    if (evq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: got pulse at cycle %0d, expected none", m_cyc);
                    end else begin
                        ev = evq.pop_front();
                        check("event_cycle", m_cyc, ev.cyc);
                        check("event_is_error", 32'(dir_error), 32'(ev.is_err));
                        check("event_clockwise", 32'(clockwise), 32'(ev.cw));
                    end
                end else if (evq.size() != 0 && evq[0].cyc <= m_cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_event: got no pulse at cycle %0d, expected one", m_cyc);
                    void'(evq.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit [1:0] seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic drive(input bit a, input bit b, input int n);
        hall_1_raw = a;
        hall_2_raw = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        finish_sim();
    end

    initial begin
        int n, s0, e0, h0, p;
        bit ca, cb;

        // 1: reset with toggling inputs, then release latency
        repeat (3) begin
            @(negedge CLK);
            hall_1_raw = 1'($urandom_range(1, 0));
            hall_2_raw = 1'($urandom_range(1, 0));
        end
        @(negedge CLK);
        reset = 1'b0;
        hall_1_raw = 1'b1;
        hall_2_raw = 1'b0;
        n = 0;
        while (!hall_1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("release_latency", n, SYNC + FL);
        $display("reset release: hall_1 followed raw after %0d cycles", n);
        drive(0, 0, 20);

        // 2: glitch rejection
        s0 = dut_steps; h0 = h1_high;
        drive(1, 0, 3);
        drive(0, 0, 20);
        check("glitch3_hall_1_cycles", h1_high - h0, 0);
        check("glitch3_steps", dut_steps - s0, 0);
        s0 = dut_steps; h0 = h1_high;
        drive(1, 0, 4);
        drive(0, 0, 20);
        check("glitch4_hall_1_cycles", h1_high - h0, 4);
        check("glitch4_steps", dut_steps - s0, 2);
        $display("glitch test: 3-cycle and 4-cycle pulses applied");

        // 3: clockwise run, 3 electrical cycles, 8-cycle holds
        s0 = dut_steps; e0 = dut_derr;
        for (int e = 0; e < 3; e++)
            for (int k = 1; k <= 4; k++) drive(seq[k%4][1], seq[k%4][0], 8);
        drive(0, 0, 12);
        check("cw_steps", dut_steps - s0, 12);
        check("cw_dir_errors", dut_derr - e0, 0);
        check("cw_clockwise", 32'(clockwise), 1);
        check("cw_period", 32'(period), 32);
        check("cw_period_valid", 32'(period_valid), 1);
        $display("clockwise run: %0d steps, period %0d", dut_steps - s0, period);

        // 4: anticlockwise run with random holds, starting 00->01->11
        s0 = dut_steps;
        p = 0;
        for (int k = 0; k < 1006; k++) begin
            p = (p + 3) % 4;
            drive(seq[p][1], seq[p][0], $urandom_range(12, FL));
        end
        drive(seq[p][1], seq[p][0], 16);
        check("ccw_steps", dut_steps - s0, 1006);
        check("ccw_clockwise", 32'(clockwise), 0);
        $display("anticlockwise run: %0d steps", dut_steps - s0);

        // 5: illegal transitions; return to 00 legally first
        while (p != 0) begin
            p = (p + 3) % 4;
            drive(seq[p][1], seq[p][0], 8);
        end
        drive(0, 0, 12);
        s0 = dut_steps; e0 = dut_derr;
        ca = 1; cb = 1;
        drive(ca, cb, 12);
        check("illegal1_err_count", 32'(err_count), 1);
        check("illegal1_pulses", dut_derr - e0, 1);
        check("illegal1_steps", dut_steps - s0, 0);
        check("illegal1_clockwise", 32'(clockwise), 0);
        for (int k = 0; k < 299; k++) begin
            ca = !ca; cb = !cb;
            drive(ca, cb, $urandom_range(8, FL));
        end
        drive(ca, cb, 12);
        check("illegal_saturate", 32'(err_count), 255);
        $display("illegal transitions: err_count %0d", err_count);

        // 6: stall, resume, then asynchronous reset mid-run
        drive(ca, cb, 150);
        check("stall_flag", 32'(stalled), 1);
        check("stall_valid", 32'(period_valid), 0);
        p = pos_of(ca, cb);
        for (int k = 0; k < 8; k++) begin
            p = (p + 1) % 4;
            drive(seq[p][1], seq[p][0], 8);
        end
        drive(seq[p][1], seq[p][0], 4);
        check("resume_stalled", 32'(stalled), 0);
        check("resume_valid", 32'(period_valid), 1);
        check("resume_period", 32'(period), 32);
        for (int k = 0; k < 2; k++) begin
            p = (p + 1) % 4;
            drive(seq[p][1], seq[p][0], 8);
        end
        @(posedge CLK);
        #2 reset = 1'b1;
        #1;
        check("async_rst_period", 32'(period), 0);
        check("async_rst_err_count", 32'(err_count), 0);
        check("async_rst_stalled", 32'(stalled), 0);
        check("async_rst_clockwise", 32'(clockwise), 1);
        @(negedge CLK);
        reset = 1'b0;
        $display("stall/resume and mid-run reset applied");

        // 7: random raw activity including glitches and illegal jumps
        for (int k = 0; k < 200; k++)
            drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom_range(7, 1));
        drive(0, 0, 30);
        check("scoreboard_drained", evq.size(), 0);
        $display("random segment done: %0d steps, %0d dir errors total", dut_steps, dut_derr);

        finish_sim();
    end

endmodule
